// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one cordic_top core between NUM_REQ angle sources using round-robin
// arbitration. One operation is in flight at a time: the granted angle is
// latched, the core gets a one-cycle reset followed by a one-cycle start, and
// the core result is held on the response port, tagged with the owner's ID,
// until the consumer takes it.
//
// Optional feature (macro CORDIC_ARB_TIMEOUT_EN): a watchdog in WAIT. If the
// core does not return valid within TIMEOUT cycles, the controller answers
// with resp_err=1 and zero data, and pulses cordic_rst on that cycle. Without
// the macro, WAIT waits indefinitely and resp_err is constant 0.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   req_valid     per-requester request, held until its req_ready
//   req_angle     flattened IEEE754 angles, requester i at [32*i+31:32*i]
//   req_ready     one-hot, one-cycle accept pulse (combinational in IDLE)
//   resp_valid    result available, held until resp_ready
//   resp_ready    result consumer ready
//   resp_id       ID of the requester owning the result
//   resp_cos      cos, Q15
//   resp_sin      sin, Q15
//   resp_err      result invalid (watchdog expired)
//   cordic_rst    reset to core
//   cordic_start  start to core
//   cordic_angle  angle to core
//   cordic_cos    core cos_q15
//   cordic_sin    core sin_q15
//   cordic_valid  core valid
//
// state | meaning
// IDLE  | arbitrate; grant the first requester at or after rr_ptr
// CRST  | one-cycle reset pulse to the core
// START | one-cycle start pulse to the core, angle stable
// WAIT  | wait for core valid (or watchdog expiry)
// RESP  | present result until resp_ready

module cordic_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_angle,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [15:0]             resp_cos,
    output logic [15:0]             resp_sin,
    output logic                    resp_err,
    output logic                    cordic_rst,
    output logic                    cordic_start,
    output logic [31:0]             cordic_angle,
    input  logic [15:0]             cordic_cos,
    input  logic [15:0]             cordic_sin,
    input  logic                    cordic_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CRST  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    generate
        if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
            $error("cordic_arbiter: ID_W must equal log2(NUM_REQ)");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("cordic_arbiter: TIMEOUT must be at least 1");
        end
    endgenerate

    logic [2:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  resp_id_r;
    logic [15:0]      resp_cos_r;
    logic [15:0]      resp_sin_r;
    logic [31:0]      angle_r;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx;
    logic [31:0]      win_angle;
    logic             grant;
    logic             wd_hit;

    // Round-robin search: rotate the start point to rr_ptr. NUM_REQ is a
    // power of two, so the ID_W-bit add wraps modulo NUM_REQ for free.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr + ID_W'(i);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_angle = req_angle[32*i +: 32];
            end
        end
    end

    // Gated by rst because state only returns to IDLE on the next edge.
    assign grant     = !rst && (state == S_IDLE) && found;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;
    logic             resp_err_r;

    // Counter is 0 in the first WAIT cycle, so the hit lands on the
    // TIMEOUT-th WAIT cycle.
    assign wd_hit = (state == S_WAIT) && !cordic_valid &&
                    (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_r <= 1'b0;
        end else if (state == S_WAIT) begin
            if (cordic_valid) begin
                resp_err_r <= 1'b0;
            end else if (wd_hit) begin
                resp_err_r <= 1'b1;
            end
        end
    end

    assign resp_err = resp_err_r;
`else
    assign wd_hit   = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            resp_id_r  <= '0;
            resp_cos_r <= '0;
            resp_sin_r <= '0;
            angle_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        angle_r   <= win_angle;
                        resp_id_r <= winner;
                        rr_ptr    <= winner + ID_W'(1);
                        state     <= S_CRST;
                    end
                end
                S_CRST:  state <= S_START;
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (cordic_valid) begin
                        resp_cos_r <= cordic_cos;
                        resp_sin_r <= cordic_sin;
                        state      <= S_RESP;
                    end else if (wd_hit) begin
                        resp_cos_r <= '0;
                        resp_sin_r <= '0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid   = (state == S_RESP);
    assign resp_id      = resp_id_r;
    assign resp_cos     = resp_cos_r;
    assign resp_sin     = resp_sin_r;
    assign cordic_start = (state == S_START);
    assign cordic_angle = angle_r;
    assign cordic_rst   = rst || (state == S_CRST) || wd_hit;

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_cos;
    logic [15:0]           resp_sin;
    logic                  resp_err;
    logic                  cordic_rst;
    logic                  cordic_start;
    logic [31:0]           cordic_angle;
    logic [15:0]           cordic_cos;
    logic [15:0]           cordic_sin;
    logic                  cordic_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     cos;
        logic [15:0]     sin;
        logic            err;
    } exp_t;

    exp_t sb[$];

    cordic_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_angle    (req_angle),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_cos     (resp_cos),
        .resp_sin     (resp_sin),
        .resp_err     (resp_err),
        .cordic_rst   (cordic_rst),
        .cordic_start (cordic_start),
        .cordic_angle (cordic_angle),
        .cordic_cos   (cordic_cos),
        .cordic_sin   (cordic_sin),
        .cordic_valid (cordic_valid)
    );

    always #5 clk = ~clk;

    // Stub core: echoes the angle halves, valid 5 cycles after start.
    logic [3:0] stub_cnt;
    logic       stub_en;

    always_ff @(posedge clk) begin
        if (cordic_rst)                  stub_cnt <= 4'd0;
        else if (cordic_start && stub_en) stub_cnt <= 4'd5;
        else if (stub_cnt != 4'd0)       stub_cnt <= stub_cnt - 4'd1;
    end

    assign cordic_valid = (stub_cnt == 4'd1);
    assign cordic_cos   = cordic_angle[31:16];
    assign cordic_sin   = cordic_angle[15:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares each accepted response against the queue.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got id=%0d cos=%h sin=%h want none",
                         resp_id, resp_cos, resp_sin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id",  32'(resp_id),  32'(e.id));
                chk("resp_cos", 32'(resp_cos), 32'(e.cos));
                chk("resp_sin", 32'(resp_sin), 32'(e.sin));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_grant(input int id, input logic [31:0] ang,
                              input logic err, input logic push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1) << id);
        if (push) begin
            e.id  = ID_W'(id);
            e.cos = err ? 16'h0 : ang[31:16];
            e.sin = err ? 16'h0 : ang[15:0];
            e.err = err;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        int  n;
        logic saw;
        rst        = 1'b1;
        req_valid  = '1;
        req_angle  = '0;
        resp_ready = 1'b1;
        stub_en    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),    32'h0);
        chk("rst_resp_valid", 32'(resp_valid),   32'h0);
        chk("rst_cordic_rst", 32'(cordic_rst),   32'h1);
        chk("rst_start",      32'(cordic_start), 32'h0);
        chk("rst_angle",      cordic_angle,      32'h0);
        chk("rst_resp_id",    32'(resp_id),      32'h0);
        chk("rst_resp_cos",   32'(resp_cos),     32'h0);
        chk("rst_resp_sin",   32'(resp_sin),     32'h0);
        chk("rst_resp_err",   32'(resp_err),     32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single requester, twice (second one after rr_ptr moved past it).
        req_angle[31:0] = 32'h42B4_0000;
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0001;
            wait_grant(0, 32'h42B4_0000, 1'b0, 1'b1);
            req_valid = '0;
            @(negedge clk);
            chk("crst_pulse",  32'(cordic_rst),   32'h1);
            chk("crst_nostart", 32'(cordic_start), 32'h0);
            @(negedge clk);
            chk("start_pulse", 32'(cordic_start), 32'h1);
            chk("start_norst", 32'(cordic_rst),   32'h0);
            chk("start_angle", cordic_angle,      32'h42B4_0000);
            drain();
        end

        // All four requesting continuously.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_angle[32*i +: 32] = 32'h3F80_0000 + 32'(i);
        req_valid = 4'b1111;
        wait_grant(0, 32'h3F80_0000, 1'b0, 1'b1);
        wait_grant(1, 32'h3F80_0001, 1'b0, 1'b1);
        wait_grant(2, 32'h3F80_0002, 1'b0, 1'b1);
        wait_grant(3, 32'h3F80_0003, 1'b0, 1'b1);
        wait_grant(0, 32'h3F80_0000, 1'b0, 1'b1);
        req_valid = '0;
        drain();

        // Backpressure with a competing request waiting behind it.
        req_angle[64 +: 32] = 32'h1234_5678;
        req_angle[32 +: 32] = 32'hCAFE_BABE;
        resp_ready = 1'b0;
        req_valid  = 4'b0100;
        wait_grant(2, 32'h1234_5678, 1'b0, 1'b1);
        req_valid = 4'b0010;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_cos",   32'(resp_cos),   32'h1234);
            chk("bp_sin",   32'(resp_sin),   32'h5678);
            chk("bp_id",    32'(resp_id),    32'h2);
            chk("bp_noreq", 32'(req_ready),  32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_noreq", 32'(req_ready), 32'h0);
        wait_grant(1, 32'hCAFE_BABE, 1'b0, 1'b1);
        req_valid = '0;
        drain();

        // Reset while in WAIT discards the operation.
        req_angle[96 +: 32] = 32'h55AA_1234;
        req_valid = 4'b1000;
        wait_grant(3, 32'h55AA_1234, 1'b0, 1'b0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_cordic_rst", 32'(cordic_rst), 32'h1);
        @(negedge clk);
        chk("rstw_valid",  32'(resp_valid),   32'h0);
        chk("rstw_start",  32'(cordic_start), 32'h0);
        chk("rstw_angle",  cordic_angle,      32'h0);
        chk("rstw_id",     32'(resp_id),      32'h0);
        chk("rstw_crst",   32'(cordic_rst),   32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_angle[0 +: 32]  = 32'h1111_2222;
        req_angle[96 +: 32] = 32'h3333_4444;
        req_valid = 4'b1001;
        wait_grant(0, 32'h1111_2222, 1'b0, 1'b1);
        req_valid = 4'b1000;
        wait_grant(3, 32'h3333_4444, 1'b0, 1'b1);
        req_valid = '0;
        drain();

        // Core never answers.
        stub_en = 1'b0;
        req_angle[32 +: 32] = 32'h7777_8888;
        req_valid = 4'b0010;
`ifdef CORDIC_ARB_TIMEOUT_EN
        wait_grant(1, 32'h7777_8888, 1'b1, 1'b1);
        req_valid = '0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 32'(n), 32'd18);
        drain();
`else
        wait_grant(1, 32'h7777_8888, 1'b0, 1'b0);
        req_valid = '0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        chk("wait_forever", 32'(saw), 32'h0);
        @(posedge clk);
        #1;
        do_reset();
`endif
        stub_en = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
